serial_reg_slave: RTL and testbench

- Parametrised single-clock serial register slave, successor to the fixed 8x8 SIPO/PISO slave.
- Accepts one framed serial transaction per strobe. Each frame carries a command bit, an address and, for writes, data.
- Writes go into a configurable bank of control registers. Reads serialise either a control register or a sampled status input back out on dout.
- Adds per-frame R/W command, address-error reporting, done pulse, registered dout_valid, parametric reset values and fully posedge-only timing.

---
 rtl/serial_reg_slave.sv | 153 +++++++++++++++
 tb/tb_serial_reg_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reg_slave.sv
// serial_reg_slave: framed serial register slave (cmd, addr, wdata / rdata), LSB first.
// Writes target a control-register bank; reads return control registers or sampled status inputs.
`default_nettype none

module serial_reg_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WR     = 9,
  parameter int NUM_RD     = 8,
  parameter logic [NUM_WR*DATA_WIDTH-1:0] WR_RESET = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          strobe,
  input  logic                          din,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          addr_err,
  output logic [NUM_WR*DATA_WIDTH-1:0]  wr_regs,
  input  logic [NUM_RD*DATA_WIDTH-1:0]  rd_regs
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_WIDTH:0] WR_END    = (ADDR_WIDTH+1)'(NUM_WR);
  localparam logic [ADDR_WIDTH:0] RD_END    = (ADDR_WIDTH+1)'(NUM_WR + NUM_RD);
  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_BITS = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_COMMIT = 3'd4,
    S_LOAD   = 3'd5,
    S_RDATA  = 3'd6
  } state_t;

  state_t                       state, state_nxt;
  logic                         is_write;
  logic [ADDR_WIDTH-1:0]        addr;
  logic [DATA_WIDTH-1:0]        shreg;
  logic [CNT_W-1:0]             cnt;
  logic                         rd_err;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_bank;
  logic [ADDR_WIDTH:0]          addr_ext;
  logic                         in_wr;
  logic                         in_rd;
  logic [DATA_WIDTH-1:0]        rd_src;

  // Zero-extended so the map bounds compare without truncation.
  assign addr_ext = {1'b0, addr};
  assign in_wr    = (addr_ext < WR_END);
  assign in_rd    = !in_wr && (addr_ext < RD_END);
  assign busy     = (state != S_IDLE);

  always_comb begin
    rd_src = '0;
    for (int i = 0; i < NUM_WR; i++)
      if (addr_ext == (ADDR_WIDTH+1)'(i)) rd_src = wr_regs[i*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < NUM_RD; i++)
      if (addr_ext == (ADDR_WIDTH+1)'(NUM_WR + i)) rd_src = rd_bank[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (strobe) state_nxt = S_CMD;
      S_CMD:    state_nxt = S_ADDR;
      S_ADDR:   if (cnt == ADDR_LAST) state_nxt = is_write ? S_WDATA : S_LOAD;
      S_WDATA:  if (cnt == DATA_LAST) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      S_LOAD:   state_nxt = S_RDATA;
      S_RDATA:  if (cnt == DATA_BITS) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_regs    <= WR_RESET;
      rd_bank    <= '0;
      is_write   <= 1'b0;
      addr       <= '0;
      shreg      <= '0;
      cnt        <= '0;
      rd_err     <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      rd_bank  <= rd_regs;
      done     <= 1'b0;
      addr_err <= 1'b0;
      unique case (state)
        S_IDLE: cnt <= '0;
        S_CMD: begin
          is_write <= din;
          cnt      <= '0;
        end
        S_ADDR: begin
          addr <= {din, addr[ADDR_WIDTH-1:1]};
          cnt  <= (cnt == ADDR_LAST) ? '0 : cnt + 1'b1;
        end
        S_WDATA: begin
          shreg <= {din, shreg[DATA_WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < NUM_WR; i++)
            if (addr_ext == (ADDR_WIDTH+1)'(i)) wr_regs[i*DATA_WIDTH +: DATA_WIDTH] <= shreg;
          addr_err <= !in_wr;
          done     <= 1'b1;
          cnt      <= '0;
        end
        S_LOAD: begin
          shreg      <= rd_src >> 1;
          dout       <= rd_src[0];
          dout_valid <= 1'b1;
          rd_err     <= !(in_wr || in_rd);
          cnt        <= 1;
        end
        S_RDATA: begin
          if (cnt == DATA_BITS) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b1;
            addr_err   <= rd_err;
            cnt        <= '0;
          end else begin
            dout  <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_reg_slave.sv
// tb_serial_reg_slave: table-driven and randomized frames checked against a register-map model.
`timescale 1ns/1ps

module tb_serial_reg_slave;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NW = 9;
  localparam int NR = 8;
  localparam logic [NW*DW-1:0] WR_RST = 72'hCC << 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              strobe;
  logic              din;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              done;
  logic              addr_err;
  logic [NW*DW-1:0]  wr_regs;
  logic [NR*DW-1:0]  rd_regs;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_wr [NW];

  serial_reg_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR), .WR_RESET(WR_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .din(din), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .addr_err(addr_err),
    .wr_regs(wr_regs), .rd_regs(rd_regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         w;
    int         a;
    logic [7:0] d;
    logic       err;
    logic [7:0] val;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mdl_flat();
    logic [71:0] f;
    for (int i = 0; i < NW; i++) f[i*DW +: DW] = mdl_wr[i];
    return f;
  endfunction

  function automatic void mdl_reset();
    logic [71:0] img;
    img = WR_RST;
    for (int i = 0; i < NW; i++) mdl_wr[i] = img[i*DW +: DW];
  endfunction

  function automatic logic [7:0] mdl_read(input int a);
    if (a < NW) return mdl_wr[a];
    if (a < NW + NR) return rd_regs[(a-NW)*DW +: DW];
    return 8'h00;
  endfunction

  // Drives one full frame from IDLE and checks every output cycle by cycle.
  task automatic run_frame(input bit w, input int a, input logic [7:0] d,
                           input logic exp_err, input logic [7:0] exp_val, input int strobe_at);
    strobe = 1'b1;
    tick();
    chk("busy_after_strobe", busy, 1'b1);
    strobe = 1'b0;
    din    = w;
    tick();
    for (int i = 0; i < AW; i++) begin
      din    = a[i];
      strobe = (i == strobe_at);
      tick();
      chk("busy_addr", busy, 1'b1);
    end
    strobe = 1'b0;
    if (w) begin
      for (int i = 0; i < DW; i++) begin
        din = d[i];
        tick();
      end
      din = 1'b0;
      tick();
      if (a < NW) mdl_wr[a] = d;
      chk("wr_done", done, 1'b1);
      chk("wr_addr_err", addr_err, exp_err);
      chk("wr_regs", wr_regs, mdl_flat());
      chk("wr_busy_end", busy, 1'b0);
    end else begin
      din = 1'($urandom_range(0, 1));
      tick();
      for (int i = 0; i < DW; i++) begin
        chk("rd_valid", dout_valid, 1'b1);
        chk("rd_dout_bit", dout, exp_val[i]);
        chk("rd_no_early_done", done, 1'b0);
        tick();
      end
      chk("rd_valid_end", dout_valid, 1'b0);
      chk("rd_dout_end", dout, 1'b0);
      chk("rd_done", done, 1'b1);
      chk("rd_addr_err", addr_err, exp_err);
      chk("rd_busy_end", busy, 1'b0);
    end
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("addr_err_one_cycle", addr_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bit         w;
    int         a;
    logic [7:0] d;

    rst_n   = 1'b0;
    strobe  = 1'b0;
    din     = 1'b0;
    rd_regs = '0;
    mdl_reset();
    #12;
    chk("rst_wr_regs", wr_regs, WR_RST);
    chk("rst_dout", dout, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_slice3", wr_regs[31:24], 8'hCC);
    chk("post_rst_busy", busy, 1'b0);

    rd_regs = 64'h5A00_0000_0000_003C;
    tick();
    tick();

    tbl[0]  = '{w:1'b1, a:3,  d:8'hA5, err:1'b0, val:8'h00};
    tbl[1]  = '{w:1'b0, a:3,  d:8'h00, err:1'b0, val:8'hA5};
    tbl[2]  = '{w:1'b0, a:9,  d:8'h00, err:1'b0, val:8'h3C};
    tbl[3]  = '{w:1'b1, a:12, d:8'h77, err:1'b1, val:8'h00};
    tbl[4]  = '{w:1'b1, a:20, d:8'h55, err:1'b1, val:8'h00};
    tbl[5]  = '{w:1'b0, a:20, d:8'h00, err:1'b1, val:8'h00};
    tbl[6]  = '{w:1'b0, a:0,  d:8'h00, err:1'b0, val:8'h00};
    tbl[7]  = '{w:1'b1, a:8,  d:8'h81, err:1'b0, val:8'h00};
    tbl[8]  = '{w:1'b0, a:8,  d:8'h00, err:1'b0, val:8'h81};
    tbl[9]  = '{w:1'b0, a:16, d:8'h00, err:1'b0, val:8'h5A};
    tbl[10] = '{w:1'b0, a:17, d:8'h00, err:1'b1, val:8'h00};
    tbl[11] = '{w:1'b1, a:31, d:8'hFF, err:1'b1, val:8'h00};

    for (int k = 0; k < 12; k++)
      run_frame(tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].err, tbl[k].val, -1);

    // Strobe re-pulsed mid-address must not disturb the frame in flight.
    run_frame(1'b1, 5, 8'h3C, 1'b0, 8'h00, 2);
    run_frame(1'b0, 5, 8'h00, 1'b0, 8'h3C, 1);

    for (int k = 0; k < 40; k++) begin
      rd_regs = {$urandom, $urandom};
      tick();
      tick();
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 31);
      d = 8'($urandom);
      run_frame(w, a, d, (a >= (w ? NW : NW + NR)), mdl_read(a), -1);
    end

    // Reset asserted in the middle of a write frame's data phase.
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    din    = 1'b1;
    tick();
    for (int i = 0; i < AW; i++) begin
      din    = (i == 1);
      strobe = (i == 3);
      tick();
    end
    strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      tick();
    end
    chk("mid_busy_before_rst", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr_regs", wr_regs, WR_RST);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_valid", dout_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    din   = 1'b0;
    mdl_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_done", done, 1'b0);
      chk("post_abort_busy", busy, 1'b0);
    end
    chk("post_abort_wr_regs", wr_regs, mdl_flat());

    run_frame(1'b0, 3, 8'h00, 1'b0, 8'hCC, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
